// File: rtl/bus_decode_pkg.sv
// Shared types and fixed decode windows for the 8088 bus cycle decoder.
package bus_decode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ADDR_HELD,
        XFER,
        RELEASE
    } bus_state_t;

    typedef logic [3:0] cs_t;

    localparam int CS_MEM_LO = 0;
    localparam int CS_MEM_HI = 1;
    localparam int CS_IO_LO  = 2;
    localparam int CS_IO_HI  = 3;

    localparam logic [31:0] MEM_LO_BASE  = 32'h0000_0000;
    localparam logic [31:0] MEM_LO_LIMIT = 32'h0007_FFFF;
    localparam logic [31:0] MEM_HI_BASE  = 32'h0008_0000;
    localparam logic [31:0] MEM_HI_LIMIT = 32'h000F_FFFF;
    localparam logic [31:0] IO_LO_BASE   = 32'h0000_0000;
    localparam logic [31:0] IO_LO_LIMIT  = 32'h0000_00FF;
    localparam logic [31:0] IO_HI_BASE   = 32'h0000_1C00;
    localparam logic [31:0] IO_HI_LIMIT  = 32'h0000_1CFF;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/addr_window_decode.sv
// Combinational address-window decode: latched address and cycle type to one-hot chip select.
module addr_window_decode
    import bus_decode_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20
) (
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     iom,
    output cs_t                      cs,
    output logic                     unmapped
);

    logic [31:0] addr_ext;

    assign addr_ext = 32'(address);

    always_comb begin
        cs = '0;
        if (iom) begin
            cs[CS_IO_LO] = in_window(addr_ext, IO_LO_BASE, IO_LO_LIMIT);
            cs[CS_IO_HI] = in_window(addr_ext, IO_HI_BASE, IO_HI_LIMIT);
        end else begin
            cs[CS_MEM_LO] = in_window(addr_ext, MEM_LO_BASE, MEM_LO_LIMIT);
            cs[CS_MEM_HI] = in_window(addr_ext, MEM_HI_BASE, MEM_HI_LIMIT);
        end
        unmapped = (cs == '0);
    end

endmodule

// File: rtl/bus_cycle_decoder.sv
// 8088 bus front end: latches AD/A under ALE, decodes chip selects, tracks the bus cycle.
// Wait-state insertion on READY is built only when BUS_CYCLE_DECODER_WAIT_EN is defined.
//
// state     | meaning
// IDLE      | no cycle in progress, waiting for ALE
// LATCH     | ALE high, address being sampled
// ADDR_HELD | address decoded, waiting for RD/WR (or timeout / new ALE)
// XFER      | strobe active, CS held
// RELEASE   | strobes gone, CS dropped on exit
module bus_cycle_decoder
    import bus_decode_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int WAIT_CYCLES   = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ALE,
    input  logic                     IOM_in,
    input  logic                     RD,
    input  logic                     WR,
    input  logic [7:0]               AD,
    input  logic [ADDRESS_WIDTH-9:0] A,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic                     IOM,
    output cs_t                      CS,
    output logic                     READY,
    output logic                     UNMAPPED,
    output logic                     ERR
);

    bus_state_t state, state_nxt;
    logic [7:0] timeout_cnt;
    logic       strobe;
    logic       both_low;
    logic       timeout_hit;
    logic       capture;
    cs_t        dec_cs;
    logic       dec_unmapped;

    addr_window_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_decode (
        .address (Address),
        .iom     (IOM),
        .cs      (dec_cs),
        .unmapped(dec_unmapped)
    );

    always_comb begin
        strobe      = !RD || !WR;
        both_low    = !RD && !WR;
        timeout_hit = 1'b0;
        state_nxt   = state;
        case (state)
            IDLE:      if (ALE) state_nxt = LATCH;
            LATCH:     if (!ALE) state_nxt = ADDR_HELD;
            ADDR_HELD: begin
                if (strobe) begin
                    state_nxt = XFER;
                end else if (ALE) begin
                    state_nxt = LATCH;
                end else if (timeout_cnt == 8'd0) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            XFER:      if (RD && WR) state_nxt = RELEASE;
            RELEASE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // every edge that lands in LATCH has ALE high, so it is also a sample edge
        capture = (state_nxt == LATCH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            Address     <= '0;
            IOM         <= 1'b0;
            CS          <= '0;
            UNMAPPED    <= 1'b0;
            ERR         <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state    <= state_nxt;
            UNMAPPED <= 1'b0;
            if (capture) begin
                Address <= {A, AD};
                IOM     <= IOM_in;
            end
            if (capture || timeout_hit || state == RELEASE) begin
                CS <= '0;
            end else if (state == LATCH && !ALE) begin
                CS       <= dec_cs;
                UNMAPPED <= dec_unmapped;
            end
            if (state == LATCH) begin
                timeout_cnt <= 8'(TIMEOUT - 1);
            end else if (state == ADDR_HELD && timeout_cnt != 8'd0) begin
                timeout_cnt <= timeout_cnt - 8'd1;
            end
            if (both_low) ERR <= 1'b1;
        end
    end

`ifdef BUS_CYCLE_DECODER_WAIT_EN
    logic [2:0] wait_cnt;
    logic       xfer_entry;

    assign xfer_entry = (state == ADDR_HELD) && (state_nxt == XFER) && (CS != '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            READY    <= 1'b1;
            wait_cnt <= '0;
        end else if (timeout_hit) begin
            READY    <= 1'b1;
            wait_cnt <= '0;
        end else if (xfer_entry && WAIT_CYCLES != 0) begin
            READY    <= 1'b0;
            wait_cnt <= 3'(WAIT_CYCLES - 1);
        end else if (!READY) begin
            if (wait_cnt == 3'd0) READY <= 1'b1;
            else                  wait_cnt <= wait_cnt - 3'd1;
        end
    end
`else
    logic unused_wait_cycles;

    assign unused_wait_cycles = ^3'(WAIT_CYCLES);
    assign READY              = 1'b1;
`endif

endmodule

// File: doc/bus_cycle_decoder.md
# bus_cycle_decoder

Front end of the 8088 bus model, directly upstream of the IO and memory peripheral modules. Demultiplexes the CPU's AD/A pins by latching the address while ALE is high, classifies the cycle as memory or IO, and decodes it into one-hot chip selects. It holds the decoded `Address`/`CS`/`IOM` stable for the whole bus cycle and optionally stretches the cycle with wait states via READY.

## Interface
- `ADDRESS_WIDTH`, 20, width of latched address.
- `WAIT_CYCLES`, 2, READY-low cycles per selected transfer; legal range 0–7.
- `TIMEOUT`, 15, cycles allowed in ADDR_HELD without RD/WR before abort; legal range 1–255.
- `CLK` input 1: bus clock; all logic is on its rising edge.
- `RESET` input 1: synchronous, active-high.
- `ALE` input 1: address latch enable from the CPU.
- `IOM_in` input 1: CPU IO/M̄; 1 means an IO cycle.
- `RD` input 1: read strobe, active-low.
- `WR` input 1: write strobe, active-low.
- `AD` input 8: multiplexed address/data low byte.
- `A` input ADDRESS_WIDTH-8: upper address bits.
- `Address` output ADDRESS_WIDTH: latched address.
- `IOM` output 1: latched cycle type.
- `CS` output 4: one-hot chip select; index as defined in the package.
- `READY` output 1: high = CPU may complete.
- `UNMAPPED` output 1: one-cycle pulse when a latched address matches no window.
- `ERR` output 1: sticky protocol error.

## Operation
- States: IDLE, LATCH, ADDR_HELD, XFER, RELEASE.
- IDLE: on ALE=1, go to LATCH.
- LATCH: capture `{A,AD}` into `Address` and `IOM_in` into `IOM` every cycle ALE=1; the last sample wins. On ALE=0, decode, drive `CS`, and go to ADDR_HELD.
- Decode windows are fixed in the package:
  - CS[0]: memory 0x00000–0x7FFFF.
  - CS[1]: memory 0x80000–0xFFFFF.
  - CS[2]: IO 0x0000–0x00FF.
  - CS[3]: IO 0x1C00–0x1CFF.
  - No match: `CS`=0, `UNMAPPED` pulses, and the cycle still runs to RELEASE so the CPU is never hung.
- ADDR_HELD:
  - RD=0 or WR=0 → XFER.
  - TIMEOUT cycles with no strobe → IDLE and clear `CS`.
  - ALE=1 → LATCH (new cycle restarts and overrides the current one).
- XFER: hold until both strobes are high, then go to RELEASE.
- RELEASE: drop `CS` and go to IDLE. `Address` and `IOM` keep their values.
- RD=0 and WR=0 in the same cycle in any state: set `ERR`, treat the cycle as a read. `ERR` clears only on RESET.
- RESET in any state: next state IDLE; all outputs go to reset values on the following edge.

## Timing
- Reset values:
  - `Address`=0, `IOM`=0, `CS`=0.
  - `READY`=1.
  - `UNMAPPED`=0, `ERR`=0.
- `CS` is registered and becomes valid on the edge that leaves LATCH, i.e. one cycle after ALE falls. `UNMAPPED` pulses on that same edge.
- `CS` is deasserted on the edge that leaves RELEASE, i.e. two cycles after the last strobe rises.
- Strobe-to-XFER latency is one cycle.
- Back-to-back: ALE in the cycle after RELEASE is accepted with no dead cycle.

## Configuration
- Macro: `BUS_CYCLE_DECODER_WAIT_EN`.
- Defined: on entry to XFER with any `CS` set, `READY` goes low for exactly WAIT_CYCLES cycles via a down-counter, then returns high. WAIT_CYCLES=0 means `READY` never drops.
- Unmapped cycles never drop `READY`. Timeout and RESET force `READY`=1.
- Not defined: `READY` is tied to 1, no counter is built, and WAIT_CYCLES is ignored.

## Structure
- Package `bus_decode_pkg` holds:
  - the state enum;
  - the window base/limit constants and the CS index constants;
  - the `cs_t` type (logic [3:0]).
- One sub-module, `addr_window_decode`: combinational, takes (address, iom) and returns (cs_t, unmapped). The parent registers its outputs. This keeps the decode table separately testable.

## Test plan
- Memory read: ALE with A=0x8_12, AD=0x34, IOM_in=0, then RD low for 3 cycles → `Address`=0x81234, `CS`=4'b0010 one cycle after ALE falls, `CS`=0 two cycles after RD rises.
- IO write with macro defined, WAIT_CYCLES=2: address 0x01C05, IOM_in=1, WR low → `CS`=4'b1000, `READY` low for exactly 2 cycles starting the cycle after WR falls.
- Unmapped IO address 0x0300 → `CS`=0, one-cycle `UNMAPPED` pulse, `READY` stays 1, FSM returns to IDLE after RD rises.
- ALE with no strobe for TIMEOUT=15 cycles → `CS` clears on the 15th cycle, FSM in IDLE; a new ALE next cycle decodes normally.
- RD and WR low together during XFER → `ERR`=1 and it stays 1 across later good cycles until RESET.
- RESET asserted mid-XFER, with `READY` low under the macro → next edge: `CS`=0, `READY`=1, `ERR`=0, state IDLE.
